adc_window_capture: RTL
=======================

ADC_WINDOW_CAPTURE -- requirements
Module: adc_window_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 12, the ADC sample width.
REQ-002 SHALL have parameter MAX_SAMPLES, default 64, the maximum samples accumulated per window.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the result-queue entries (power of two).
REQ-004 SHALL have the ports below; one clock; reset is asynchronous and active-high.
- fpga_clk  in  1  system clock; all logic on its rising edge.
- sys_init_ctrl  in  1  asynchronous active-high reset.
- adc_en  in  1  acquisition window from the sequencer FSM; high = window open.
- rf_sw  in  4  one-hot RF switch select from the sequencer.
- rot_count  in  10  current rotation index from the sequencer.
- adc_drdy  in  1  one-cycle sample strobe, synchronous to fpga_clk.
- adc_data  in  DATA_W  unsigned sample, valid when adc_drdy=1.
- res_ready  in  1  downstream accepts the head result.
- res_valid  out  1  head result available.
- res_sum  out  DATA_W+6  sum of the window's samples.
- res_cnt  out  7  number of samples summed (0..MAX_SAMPLES).
- res_ch  out  2  encoded RF channel.
- res_rot  out  10  rot_count captured at window open.
- ovf_err  out  1  sticky: a sample arrived after MAX_SAMPLES was reached.
- drop_err  out  1  sticky: a result was discarded because the queue was full.
- chsel_err  out  1  sticky: rf_sw was not one-hot at window open.

Function
REQ-005 SHALL register adc_en into adc_en_d; rise = adc_en & ~adc_en_d; fall = ~adc_en & adc_en_d.
REQ-006 SHALL implement FSM states IDLE, ACQ, COMMIT.
REQ-007 IDLE -> ACQ on rise; on that edge, clear the accumulator and count, and latch rot_count and the encoded rf_sw.
REQ-008 SHALL encode rf_sw as 0001->0, 0010->1, 0100->2, 1000->3; any other value gives channel 0 and sets chsel_err.
REQ-009 In ACQ, each cycle with adc_en=1 and adc_drdy=1 (including the rise cycle) SHALL add adc_data and increment the count; no sample is taken on the fall cycle.
REQ-010 When count = MAX_SAMPLES, further strobes SHALL be dropped (sum and count unchanged) and SHALL set ovf_err.
REQ-011 ACQ -> COMMIT on fall; COMMIT lasts exactly one cycle and writes {sum, cnt, ch, rot} into the FIFO at its closing edge.
REQ-012 COMMIT -> ACQ if rise is sampled in the COMMIT cycle (new window, cleared accumulator); otherwise COMMIT -> IDLE.
REQ-013 If the FIFO is full at the COMMIT write and no pop occurs in the same cycle, the entry SHALL be discarded and drop_err set; a simultaneous pop SHALL free space and the write SHALL succeed.
REQ-014 res_valid SHALL equal FIFO-not-empty; res_* SHALL show the head entry; a pop occurs when res_valid & res_ready.
REQ-015 Latency: fall sampled at edge k gives res_valid=1 after edge k+1 when the FIFO was empty.
REQ-016 A window with zero samples SHALL still commit, with res_cnt=0 and res_sum=0.
REQ-017 The accumulator SHALL be DATA_W+6 bits wide; it cannot overflow at MAX_SAMPLES=64.
REQ-018 Error flags SHALL stay set until reset.

Reset
REQ-019 sys_init_ctrl=1 SHALL asynchronously force the following: state IDLE; adc_en_d=0; accumulator, count and latches 0; FIFO empty; res_valid=0; res_* outputs 0; all error flags 0.
REQ-020 A reset mid-window SHALL discard the partial result; acquisition resumes only on a fresh rise after release.

Structure
REQ-021 The state encoding, the one-hot-to-index function and the MAX_SAMPLES/FIFO_DEPTH defaults SHALL live in a shared package.
REQ-022 The result queue SHALL be one sub-module, result_fifo, a synchronous FIFO with full/empty flags and a width parameter.

Verification
REQ-023 Single window: rf_sw=0010, rot_count=5, 30 strobes of value 100 -> one result: sum=3000, cnt=30, ch=1, rot=5; res_valid rises 2 edges after adc_en falls.
REQ-024 Overflow: 70 strobes of value 4095 in one window -> sum=262080, cnt=64, ovf_err=1.
REQ-025 Backpressure: res_ready=0 over 5 windows -> the first 4 results are held in order and drop_err=1; then res_ready=1 -> exactly 4 pops.
REQ-026 Bad select: rf_sw=0110 at rise -> ch=0 and chsel_err=1; the result is still committed.
REQ-027 Reset mid-window: sys_init_ctrl pulsed after 10 strobes -> no result, res_valid=0; the next window counts from 0.
REQ-028 Back-to-back: adc_en low for exactly 1 cycle between windows -> two separate results, and the second sum excludes the first window's samples.

Source files
------------

// File: rtl/adc_window_capture_pkg.sv
// Shared definitions for the ADC window capture block: FSM states, default sizes
// and the RF switch one-hot decoder.
package adc_window_capture_pkg;

  localparam int MAX_SAMPLES_DEF = 64;
  localparam int FIFO_DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Returns {invalid, index}; anything that is not one-hot maps to channel 0 with invalid set.
  function automatic logic [2:0] onehot_to_idx(input logic [3:0] sel);
    logic [2:0] res;
    case (sel)
      4'b0001: res = 3'b000;
      4'b0010: res = 3'b001;
      4'b0100: res = 3'b010;
      4'b1000: res = 3'b011;
      default: res = 3'b100;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/adc_window_capture_fifo.sv
// result_fifo: synchronous FIFO holding committed window results; the head entry is
// always visible on rd_data, and a write into a full FIFO succeeds only alongside a pop.
module result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_rd_s;
  logic             do_wr_s;

  assign full    = (count_r == (AW+1)'(DEPTH));
  assign empty   = (count_r == '0);
  assign do_rd_s = rd_en & ~empty;
  assign do_wr_s = wr_en & (~full | do_rd_s);
  assign rd_data = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_wr_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (do_rd_s) rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/adc_window_capture.sv
// Accumulates ADC samples over each adc_en window and queues one
// {sum, count, channel, rotation} result per window for the downstream reader.
module adc_window_capture
  import adc_window_capture_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int MAX_SAMPLES = MAX_SAMPLES_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic              fpga_clk,
  input  logic              sys_init_ctrl,
  input  logic              adc_en,
  input  logic [3:0]        rf_sw,
  input  logic [9:0]        rot_count,
  input  logic              adc_drdy,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              res_ready,
  output logic              res_valid,
  output logic [DATA_W+5:0] res_sum,
  output logic [6:0]        res_cnt,
  output logic [1:0]        res_ch,
  output logic [9:0]        res_rot,
  output logic              ovf_err,
  output logic              drop_err,
  output logic              chsel_err
);

  localparam int SUM_W   = DATA_W + 6;
  localparam int ENTRY_W = SUM_W + 7 + 2 + 10;

  state_e             state_r;
  logic               adc_en_d_r;
  logic [SUM_W-1:0]   acc_r;
  logic [6:0]         cnt_r;
  logic [1:0]         ch_r;
  logic [9:0]         rot_r;
  logic               ovf_err_r;
  logic               drop_err_r;
  logic               chsel_err_r;

  logic               rise_s;
  logic               fall_s;
  logic               take_s;
  logic [2:0]         sel_dec_s;
  logic               commit_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [ENTRY_W-1:0] head_s;

  assign rise_s    = adc_en & ~adc_en_d_r;
  assign fall_s    = ~adc_en & adc_en_d_r;
  assign take_s    = adc_en & adc_drdy;
  assign sel_dec_s = onehot_to_idx(rf_sw);
  assign commit_s  = (state_r == ST_COMMIT);

  // Window sequencing, accumulation and the sticky error flags.
  always_ff @(posedge fpga_clk or posedge sys_init_ctrl) begin
    if (sys_init_ctrl) begin
      state_r     <= ST_IDLE;
      adc_en_d_r  <= 1'b0;
      acc_r       <= '0;
      cnt_r       <= 7'd0;
      ch_r        <= 2'd0;
      rot_r       <= 10'd0;
      ovf_err_r   <= 1'b0;
      drop_err_r  <= 1'b0;
      chsel_err_r <= 1'b0;
    end else begin
      adc_en_d_r <= adc_en;
      if (commit_s && fifo_full_s && !res_ready) drop_err_r <= 1'b1;

      // A rise seen in IDLE or in the COMMIT cycle opens a fresh window, sampling on that same cycle.
      if (rise_s && (state_r == ST_IDLE || state_r == ST_COMMIT)) begin
        state_r <= ST_ACQ;
        acc_r   <= take_s ? SUM_W'(adc_data) : '0;
        cnt_r   <= take_s ? 7'd1 : 7'd0;
        ch_r    <= sel_dec_s[1:0];
        rot_r   <= rot_count;
        if (sel_dec_s[2]) chsel_err_r <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: state_r <= ST_IDLE;
          ST_ACQ: begin
            if (fall_s) begin
              state_r <= ST_COMMIT;
            end else if (take_s) begin
              if (cnt_r == 7'(MAX_SAMPLES)) begin
                ovf_err_r <= 1'b1;
              end else begin
                acc_r <= acc_r + SUM_W'(adc_data);
                cnt_r <= cnt_r + 7'd1;
              end
            end
          end
          ST_COMMIT: state_r <= ST_IDLE;
          default:   state_r <= ST_IDLE;
        endcase
      end
    end
  end

  result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk     (fpga_clk),
    .rst     (sys_init_ctrl),
    .wr_en   (commit_s),
    .wr_data ({acc_r, cnt_r, ch_r, rot_r}),
    .rd_en   (res_ready),
    .rd_data (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign res_valid = ~fifo_empty_s;
  assign res_sum   = head_s[ENTRY_W-1 -: SUM_W];
  assign res_cnt   = head_s[18:12];
  assign res_ch    = head_s[11:10];
  assign res_rot   = head_s[9:0];
  assign ovf_err   = ovf_err_r;
  assign drop_err  = drop_err_r;
  assign chsel_err = chsel_err_r;

endmodule
